// File: rtl/aes_pkg.sv
// Shared definitions for the byte-serial AES-128 core: state encoding,
// phase limits, round-constant seed and the GF(2^8) xtime helper.
package aes_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    ROUND = ST_ROUND,
    OUT   = ST_OUT
  } aes_state_t;

  localparam logic [3:0] LAST_BYTE  = 4'd15;
  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [7:0] RCON_INIT  = 8'h01;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads the seed on init, steps by xtime on advance.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       ClkxCI,
  input  logic       RstxRI,
  input  logic       InitxSI,
  input  logic       AdvxSI,
  output logic [7:0] RconxDO
);

  logic [7:0] rconxDP;

  always_ff @(posedge ClkxCI) begin
    if (RstxRI || InitxSI) rconxDP <= RCON_INIT;
    else if (AdvxSI)       rconxDP <= xtime(rconxDP);
  end

  assign RconxDO = rconxDP;

endmodule

// File: rtl/aes_ctrl.sv
// Round/byte scheduler for the byte-serial AES-128 datapath: 16 load cycles,
// ten 16-cycle rounds and 16 output cycles per block, all outputs Moore decodes.
module aes_ctrl
  import aes_pkg::*;
(
  input  logic       ClkxCI,
  input  logic       RstxRI,
  input  logic       StartxSI,
  output logic       BusyxSO,
  output logic       SelPlainxSO,
  output logic       DinReqxSO,
  output logic       ShiftRowsxSO,
  output logic       MixColumnsxSO,
  output logic       KeyEnxSO,
  output logic       KeyRoundxSO,
  output logic [7:0] RconxDO,
  output logic [3:0] RoundxDO,
  output logic [3:0] ByteCntxDO,
  output logic       DoutValidxSO,
  output logic       DonexSO
);

  aes_state_t statexDP, statexDN;
  logic [3:0] byteCntxDP, byteCntxDN;
  logic [3:0] roundxDP, roundxDN;
  logic       rconInit, rconAdv;
  logic       lastByte;

  assign lastByte = (byteCntxDP == LAST_BYTE);

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      statexDP   <= IDLE;
      byteCntxDP <= '0;
      roundxDP   <= '0;
    end else begin
      statexDP   <= statexDN;
      byteCntxDP <= byteCntxDN;
      roundxDP   <= roundxDN;
    end
  end

  always_comb begin
    statexDN      = statexDP;
    byteCntxDN    = byteCntxDP + 4'd1;
    roundxDN      = roundxDP;
    rconInit      = 1'b0;
    rconAdv       = 1'b0;
    BusyxSO       = 1'b0;
    SelPlainxSO   = 1'b0;
    DinReqxSO     = 1'b0;
    ShiftRowsxSO  = 1'b0;
    MixColumnsxSO = 1'b0;
    KeyEnxSO      = 1'b0;
    KeyRoundxSO   = 1'b0;
    DoutValidxSO  = 1'b0;
    DonexSO       = 1'b0;
    case (statexDP)
      IDLE: begin
        byteCntxDN = '0;
        roundxDN   = '0;
        rconInit   = 1'b1;
        if (StartxSI) statexDN = LOAD;
      end
      LOAD: begin
        BusyxSO     = 1'b1;
        SelPlainxSO = 1'b1;
        DinReqxSO   = 1'b1;
        KeyEnxSO    = 1'b1;
        if (lastByte) begin
          KeyRoundxSO = 1'b1;
          roundxDN    = 4'd1;
          statexDN    = ROUND;
        end
      end
      ROUND: begin
        BusyxSO  = 1'b1;
        KeyEnxSO = 1'b1;
        // Round 1 has no MixColumns slot: the loaded state is mixed only from round 2 on.
        if (lastByte) ShiftRowsxSO = 1'b1;
        else if (byteCntxDP[1:0] == 2'b00 && roundxDP >= 4'd2) MixColumnsxSO = 1'b1;
        if (lastByte) begin
          if (roundxDP == LAST_ROUND) begin
            statexDN = OUT;
          end else begin
            KeyRoundxSO = 1'b1;
            roundxDN    = roundxDP + 4'd1;
            rconAdv     = 1'b1;
          end
        end
      end
      OUT: begin
        BusyxSO      = 1'b1;
        KeyEnxSO     = 1'b1;
        DoutValidxSO = 1'b1;
        // Clear round and Rcon on exit so the first IDLE cycle already shows reset values.
        if (lastByte) begin
          DonexSO  = 1'b1;
          roundxDN = '0;
          rconInit = 1'b1;
          statexDN = IDLE;
        end
      end
      default: begin
        statexDN   = IDLE;
        byteCntxDN = '0;
        roundxDN   = '0;
        rconInit   = 1'b1;
      end
    endcase
  end

  aes_rcon_gen u_rcon (
    .ClkxCI (ClkxCI),
    .RstxRI (RstxRI),
    .InitxSI(rconInit),
    .AdvxSI (rconAdv),
    .RconxDO(RconxDO)
  );

  assign RoundxDO   = roundxDP;
  assign ByteCntxDO = byteCntxDP;

endmodule

// File: tb/tb_aes_ctrl.sv
// Self-checking bench for aes_ctrl: a block-position reference model predicts
// every output each cycle under directed and randomized start/reset stimulus.
module tb_aes_ctrl;

  logic       ClkxCI = 1'b0;
  logic       RstxRI = 1'b1;
  logic       StartxSI = 1'b0;
  logic       BusyxSO, SelPlainxSO, DinReqxSO, ShiftRowsxSO, MixColumnsxSO;
  logic       KeyEnxSO, KeyRoundxSO, DoutValidxSO, DonexSO;
  logic [7:0] RconxDO;
  logic [3:0] RoundxDO, ByteCntxDO;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int ph      = 0;  // 0 = idle, 1..192 = cycle offset within the running block

  logic [7:0] rconTab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_ctrl dut (
    .ClkxCI       (ClkxCI),
    .RstxRI       (RstxRI),
    .StartxSI     (StartxSI),
    .BusyxSO      (BusyxSO),
    .SelPlainxSO  (SelPlainxSO),
    .DinReqxSO    (DinReqxSO),
    .ShiftRowsxSO (ShiftRowsxSO),
    .MixColumnsxSO(MixColumnsxSO),
    .KeyEnxSO     (KeyEnxSO),
    .KeyRoundxSO  (KeyRoundxSO),
    .RconxDO      (RconxDO),
    .RoundxDO     (RoundxDO),
    .ByteCntxDO   (ByteCntxDO),
    .DoutValidxSO (DoutValidxSO),
    .DonexSO      (DonexSO)
  );

  always #5 ClkxCI = ~ClkxCI;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] obsVec();
    return {7'd0, BusyxSO, SelPlainxSO, DinReqxSO, ShiftRowsxSO, MixColumnsxSO,
            KeyEnxSO, KeyRoundxSO, DoutValidxSO, DonexSO, RconxDO, RoundxDO, ByteCntxDO};
  endfunction

  // Expected outputs from the block timeline: load at 1..16, round r at
  // 16r+1..16r+16, output at 177..192.
  function automatic logic [31:0] expVec(input int p);
    logic isLoad, isRnd, isOut, busy, sr, mc, kr, done;
    int   b, rnd;
    logic [7:0] rc;
    isLoad = (p >= 1 && p <= 16);
    isRnd  = (p >= 17 && p <= 176);
    isOut  = (p >= 177);
    busy   = (p != 0);
    b      = (p == 0) ? 0 : (p - 1) % 16;
    rnd    = isRnd ? (p - 1) / 16 : (isOut ? 10 : 0);
    rc     = (rnd >= 1) ? rconTab[rnd-1] : 8'h01;
    sr     = isRnd && b == 15;
    mc     = isRnd && rnd >= 2 && (b % 4) == 0;
    kr     = (isLoad || isRnd) && b == 15 && rnd <= 9;
    done   = (p == 192);
    return {7'd0, busy, isLoad, isLoad, sr, mc, busy, kr, isOut, done,
            rc, 4'(rnd), 4'(b)};
  endfunction

  task automatic step(input logic s, input logic r);
    StartxSI = s;
    RstxRI   = r;
    @(posedge ClkxCI);
    cyc++;
    if (r)                ph = 0;
    else if (ph == 0)     ph = s ? 1 : 0;
    else if (ph == 192)   ph = 0;
    else                  ph++;
    @(negedge ClkxCI);
    chk("outs", obsVec(), expVec(ph));
    chk("sr_mc_overlap", 32'(ShiftRowsxSO & MixColumnsxSO), 32'd0);
  endtask

  initial begin
    int doneAt, busyFall, dinCnt, srCnt, mcCnt, krCnt, reload, doneCnt;
    logic prevDin;

    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_state", obsVec(), 32'h0000_0100);
    step(1'b0, 1'b0);

    // Single start pulse: latency, framing and strobe counts.
    step(1'b1, 1'b0);
    chk("busy_rise", 32'(BusyxSO), 32'd1);
    doneAt = 0; busyFall = 0; dinCnt = 1; srCnt = 0; mcCnt = 0; krCnt = 0;
    for (int k = 2; k <= 200; k++) begin
      step(1'b0, 1'b0);
      if (DonexSO && doneAt == 0) doneAt = k;
      if (!BusyxSO && busyFall == 0) busyFall = k;
      dinCnt += int'(DinReqxSO);
      srCnt  += int'(ShiftRowsxSO);
      mcCnt  += int'(MixColumnsxSO);
      krCnt  += int'(KeyRoundxSO);
      if (BusyxSO && !DinReqxSO && !DoutValidxSO && ByteCntxDO == 4'd0 &&
          RoundxDO >= 4'd1 && RoundxDO <= 4'd10)
        chk("rcon_round", 32'(RconxDO), 32'(rconTab[RoundxDO-4'd1]));
    end
    chk("done_at", 32'(doneAt), 32'd192);
    chk("busy_fall", 32'(busyFall), 32'd193);
    chk("din_cnt", 32'(dinCnt), 32'd16);
    chk("sr_cnt", 32'(srCnt), 32'd10);
    chk("mc_cnt", 32'(mcCnt), 32'd36);
    chk("kr_cnt", 32'(krCnt), 32'd10);

    // Start held high: one block, then the next load at t+194.
    step(1'b1, 1'b0);
    reload = 0; doneCnt = 0; prevDin = DinReqxSO;
    for (int k = 2; k <= 200; k++) begin
      step(1'b1, 1'b0);
      if (k <= 193) doneCnt += int'(DonexSO);
      if (DinReqxSO && !prevDin && reload == 0) reload = k;
      prevDin = DinReqxSO;
    end
    chk("held_done_cnt", 32'(doneCnt), 32'd1);
    chk("held_reload", 32'(reload), 32'd194);
    step(1'b0, 1'b1);

    // Reset in round 5 at byte 7: idle next cycle, no trailing Done.
    step(1'b1, 1'b0);
    while (ph != 88) step(1'b0, 1'b0);
    chk("pre_rst_pos", 32'({RoundxDO, ByteCntxDO}), 32'h57);
    step(1'b0, 1'b1);
    chk("rst_mid", obsVec(), 32'h0000_0100);
    doneCnt = 0;
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'b0);
      doneCnt += int'(DonexSO);
    end
    chk("rst_no_done", 32'(doneCnt), 32'd0);

    // Randomized start and reset traffic against the model.
    for (int k = 0; k < 4000; k++)
      step(($urandom % 6) == 0, ($urandom % 400) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
